// File: rtl/ldpc_serial_encoder.sv
// ldpc_serial_encoder: bit-serial systematic LDPC encoder.
// The parity-check rows are loaded once after reset. Each message is then
// encoded one bit per cycle into a codeword {parity, msg}.
// Optional build macro LDPC_GMAT_READ_EN adds a generator-row read port.
module ldpc_serial_encoder #(
  parameter int K = 3,
  parameter int M = 3,
  localparam int N = K + M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         h_valid,
  output logic         h_ready,
  input  logic [N-1:0] h_row,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [K-1:0] msg,
  output logic         cw_valid,
  input  logic         cw_ready,
  output logic [N-1:0] cw,
  output logic         busy
`ifdef LDPC_GMAT_READ_EN
  ,
  input  logic                 g_rd_en,
  input  logic [$clog2(K)-1:0] g_rd_idx,
  output logic [N-1:0]         g_row,
  output logic                 g_rd_valid
`endif
);

  localparam int KW = $clog2(K);
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {LOAD, READY, CALC, OUT} state_e;

  state_e          state_q;
  logic [RW-1:0]   row_q;
  logic [KW-1:0]   bit_q;
  // Only the P part of each H row is kept; hp_q[r][K-1-k] is h_r[N-1-k].
  logic [K-1:0]    hp_q [M];
  logic [K-1:0]    msg_q;
  logic [M-1:0]    parity_q;
  logic [M-1:0]    parity_d;
  logic [N-1:0]    cw_q;
  logic            h_ready_q;
  logic            msg_ready_q;
  logic            cw_valid_q;
  logic            busy_q;
  logic            unused_h_low;

  // The identity part of each H row carries no information for encoding.
  assign unused_h_low = ^h_row[M-1:0];

  // Fold the H column selected by the current message bit into the parity.
  always_comb begin
    parity_d = parity_q;
    for (int k = 0; k < K; k++) begin
      if (bit_q == KW'(k) && msg_q[k]) begin
        for (int r = 0; r < M; r++) begin
          parity_d[r] = parity_q[r] ^ hp_q[r][K-1-k];
        end
      end
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      row_q       <= '0;
      bit_q       <= '0;
      for (int r = 0; r < M; r++) hp_q[r] <= '0;
      msg_q       <= '0;
      parity_q    <= '0;
      cw_q        <= '0;
      h_ready_q   <= 1'b1;
      msg_ready_q <= 1'b0;
      cw_valid_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          if (h_valid && h_ready_q) begin
            hp_q[row_q] <= h_row[N-1:M];
            if (row_q == RW'(M-1)) begin
              row_q       <= '0;
              state_q     <= READY;
              h_ready_q   <= 1'b0;
              msg_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        READY: begin
          if (msg_valid && msg_ready_q) begin
            msg_q       <= msg;
            parity_q    <= '0;
            bit_q       <= '0;
            state_q     <= CALC;
            msg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        CALC: begin
          parity_q <= parity_d;
          if (bit_q == KW'(K-1)) begin
            bit_q      <= '0;
            state_q    <= OUT;
            cw_q       <= {parity_d, msg_q};
            cw_valid_q <= 1'b1;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        OUT: begin
          if (cw_ready && cw_valid_q) begin
            state_q     <= READY;
            cw_valid_q  <= 1'b0;
            msg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign h_ready   = h_ready_q;
  assign msg_ready = msg_ready_q;
  assign cw_valid  = cw_valid_q;
  assign cw        = cw_q;
  assign busy      = busy_q;

`ifdef LDPC_GMAT_READ_EN
  logic [N-1:0] g_d;
  logic [N-1:0] g_row_q;
  logic         g_rd_valid_q;

  // Build generator row g_k; out-of-range indices leave it all zero.
  always_comb begin
    g_d = '0;
    for (int k = 0; k < K; k++) begin
      if (g_rd_idx == KW'(k)) begin
        g_d[k] = 1'b1;
        for (int r = 0; r < M; r++) begin
          g_d[K+r] = hp_q[r][K-1-k];
        end
      end
    end
  end

  // Register the generator row one cycle after a read request outside LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_row_q      <= '0;
      g_rd_valid_q <= 1'b0;
    end else begin
      g_rd_valid_q <= g_rd_en && (state_q != LOAD);
      if (g_rd_en && (state_q != LOAD)) begin
        g_row_q <= g_d;
      end
    end
  end

  assign g_row      = g_row_q;
  assign g_rd_valid = g_rd_valid_q;
`endif

endmodule

// File: tb/tb_ldpc_serial_encoder.sv
// Testbench for ldpc_serial_encoder (K=3, M=3) with a codeword scoreboard.
module tb_ldpc_serial_encoder;

  localparam int K = 3;
  localparam int M = 3;
  localparam int N = K + M;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         h_valid;
  logic         h_ready;
  logic [N-1:0] h_row;
  logic         msg_valid;
  logic         msg_ready;
  logic [K-1:0] msg;
  logic         cw_valid;
  logic         cw_ready;
  logic [N-1:0] cw;
  logic         busy;
`ifdef LDPC_GMAT_READ_EN
  logic                 gRdEn;
  logic [$clog2(K)-1:0] gRdIdx;
  logic [N-1:0]         gRow;
  logic                 gRdValid;
`endif

  logic [N-1:0] hMat [M];
  logic [N-1:0] expQ [$];
  int           checkCount = 0;
  int           passCount = 0;

  always #5 clk = ~clk;

  ldpc_serial_encoder #(.K(K), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_valid   (h_valid),
    .h_ready   (h_ready),
    .h_row     (h_row),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg       (msg),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw        (cw),
    .busy      (busy)
`ifdef LDPC_GMAT_READ_EN
    ,
    .g_rd_en   (gRdEn),
    .g_rd_idx  (gRdIdx),
    .g_row     (gRow),
    .g_rd_valid(gRdValid)
`endif
  );

  // Reference codeword: systematic msg plus parity p_r = XOR_k msg[k] & h_r[N-1-k].
  function automatic logic [N-1:0] modelCw(input logic [K-1:0] m);
    logic [N-1:0] c;
    c = '0;
    c[K-1:0] = m;
    for (int r = 0; r < M; r++)
      for (int k = 0; k < K; k++)
        if (m[k]) c[K+r] = c[K+r] ^ hMat[r][N-1-k];
    return c;
  endfunction

  // Offer one message for a single cycle and record its expected codeword.
  task automatic drive_msg(input logic [K-1:0] m);
    msg_valid = 1'b1;
    msg = m;
    expQ.push_back(modelCw(m));
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; h_valid = 1'b0; h_row = '0; msg_valid = 1'b0; msg = '0; cw_ready = 1'b0;
`ifdef LDPC_GMAT_READ_EN
    gRdEn = 1'b0; gRdIdx = '0;
`endif
    repeat (2) @(negedge clk);
    checkCount++; if (h_ready !== 1'b1) $display("[TB] FAIL reset_h_ready got %b want 1", h_ready); else passCount++;
    checkCount++; if (msg_ready !== 1'b0) $display("[TB] FAIL reset_msg_ready got %b want 0", msg_ready); else passCount++;
    checkCount++; if (cw_valid !== 1'b0) $display("[TB] FAIL reset_cw_valid got %b want 0", cw_valid); else passCount++;
    checkCount++; if (cw !== '0) $display("[TB] FAIL reset_cw got %b want 0", cw); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy got %b want 1", busy); else passCount++;
`ifdef LDPC_GMAT_READ_EN
    checkCount++; if (gRow !== '0 || gRdValid !== 1'b0) $display("[TB] FAIL reset_g got %b/%b want 0/0", gRow, gRdValid); else passCount++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    for (int r = 0; r < M; r++) begin
      checkCount++; if (h_ready !== 1'b1) $display("[TB] FAIL load_h_ready row %0d got %b want 1", r, h_ready); else passCount++;
      h_valid = 1'b1;
      h_row = hMat[r];
      @(negedge clk);
    end
    h_row = '1;
    checkCount++; if (h_ready !== 1'b0 || msg_ready !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL load_done got h_ready=%b msg_ready=%b busy=%b want 0 1 0", h_ready, msg_ready, busy);
    else passCount++;
    // A stray H beat outside LOAD must not disturb the stored rows.
    repeat (2) @(negedge clk);
    h_valid = 1'b0;
    h_row = '0;
  endtask

  task automatic test_encode_basic();
    int n;
    logic [N-1:0] exp;
    checkCount++; if (msg_ready !== 1'b1) $display("[TB] FAIL enc_msg_ready got %b want 1", msg_ready); else passCount++;
    drive_msg(3'b101);
    checkCount++; if (busy !== 1'b1 || cw_valid !== 1'b0) $display("[TB] FAIL enc_calc got busy=%b cw_valid=%b want 1 0", busy, cw_valid); else passCount++;
    n = 0;
    while (cw_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checkCount++; if (n != K) $display("[TB] FAIL enc_latency got %0d want %0d edges after handshake edge", n, K); else passCount++;
    exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
    checkCount++; if (cw !== exp) $display("[TB] FAIL enc_cw got %b want %b", cw, exp); else passCount++;
    checkCount++; if (cw !== 6'b110101) $display("[TB] FAIL enc_cw_const got %b want 110101", cw); else passCount++;
    cw_ready = 1'b1;
    @(negedge clk);
    cw_ready = 1'b0;
    checkCount++; if (cw_valid !== 1'b0 || msg_ready !== 1'b1) $display("[TB] FAIL enc_release got cw_valid=%b msg_ready=%b want 0 1", cw_valid, msg_ready); else passCount++;
  endtask

  task automatic test_patterns();
    int n;
    logic [N-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive_msg(K'(i));
      n = 0;
      while (cw_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
      checkCount++; if (cw_valid !== 1'b1 || cw !== exp) $display("[TB] FAIL pattern_%0d got valid=%b cw=%b want 1 %b", i, cw_valid, cw, exp); else passCount++;
      cw_ready = 1'b1;
      @(negedge clk);
      cw_ready = 1'b0;
    end
    // Spot values worked by hand for the reference H.
    drive_msg(3'b111);
    n = 0;
    while (cw_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    void'(expQ.pop_front());
    checkCount++; if (cw !== 6'b000111) $display("[TB] FAIL pattern_111 got %b want 000111", cw); else passCount++;
    cw_ready = 1'b1; @(negedge clk); cw_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    int delivered;
    logic [N-1:0] exp;
    drive_msg(3'b101);
    n = 0;
    while (cw_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
    msg_valid = 1'b1;
    msg = 3'b010;
    for (int c = 0; c < 5; c++) begin
      checkCount++; if (cw_valid !== 1'b1 || cw !== exp || msg_ready !== 1'b0)
        $display("[TB] FAIL hold_cycle_%0d got valid=%b cw=%b msg_ready=%b want 1 %b 0", c, cw_valid, cw, msg_ready, exp);
      else passCount++;
      @(negedge clk);
    end
    cw_ready = 1'b1;
    @(negedge clk);
    cw_ready = 1'b0;
    msg_valid = 1'b0;
    delivered = 1;
    for (int c = 0; c < K + 3; c++) begin
      if (cw_valid === 1'b1 || busy === 1'b1) delivered++;
      @(negedge clk);
    end
    checkCount++; if (delivered != 1) $display("[TB] FAIL hold_single_delivery got %0d want 1", delivered); else passCount++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [N-1:0] exp;
    logic [K-1:0] seq [4] = '{3'b011, 3'b100, 3'b110, 3'b001};
    cw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_msg(seq[i]);
      n = 0;
      while (cw_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
      checkCount++; if (cw_valid !== 1'b1 || cw !== exp) $display("[TB] FAIL b2b_cw_%0d got valid=%b cw=%b want 1 %b", i, cw_valid, cw, exp); else passCount++;
      @(negedge clk);
      checkCount++; if (cw_valid !== 1'b0 || msg_ready !== 1'b1) $display("[TB] FAIL b2b_single_out_%0d got cw_valid=%b msg_ready=%b want 0 1", i, cw_valid, msg_ready); else passCount++;
    end
    cw_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    drive_msg(3'b110);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkCount++; if (h_ready !== 1'b1 || cw_valid !== 1'b0 || busy !== 1'b1 || msg_ready !== 1'b0 || cw !== '0)
      $display("[TB] FAIL abort_state got h_ready=%b cw_valid=%b busy=%b msg_ready=%b cw=%b want 1 0 1 0 0", h_ready, cw_valid, busy, msg_ready, cw);
    else passCount++;
    rst_n = 1'b1;
    expQ.delete();
    seen = 0;
    for (int c = 0; c < K + 3; c++) begin
      if (cw_valid === 1'b1 || h_ready !== 1'b1) seen++;
      @(negedge clk);
    end
    checkCount++; if (seen != 0) $display("[TB] FAIL abort_no_cw got %0d bad cycles want 0", seen); else passCount++;
  endtask

`ifdef LDPC_GMAT_READ_EN
  task automatic test_gmat();
    gRdEn = 1'b1; gRdIdx = 2'd0;
    @(negedge clk);
    gRdEn = 1'b0;
    checkCount++; if (gRdValid !== 1'b1 || gRow !== 6'b101001) $display("[TB] FAIL gmat_idx0 got valid=%b row=%b want 1 101001", gRdValid, gRow); else passCount++;
    @(negedge clk);
    checkCount++; if (gRdValid !== 1'b0) $display("[TB] FAIL gmat_valid_drop got %b want 0", gRdValid); else passCount++;
    gRdEn = 1'b1; gRdIdx = 2'd3;
    @(negedge clk);
    gRdEn = 1'b0;
    checkCount++; if (gRdValid !== 1'b1 || gRow !== '0) $display("[TB] FAIL gmat_idx3 got valid=%b row=%b want 1 000000", gRdValid, gRow); else passCount++;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    hMat[0] = 6'b101000;
    hMat[1] = 6'b011000;
    hMat[2] = 6'b110000;
    test_reset();
    test_load();
`ifdef LDPC_GMAT_READ_EN
    test_gmat();
`endif
    test_encode_basic();
    test_patterns();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    test_load();
    test_encode_basic();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ldpc_serial_encoder.md
LDPC_SERIAL_ENCODER -- requirements
Module: ldpc_serial_encoder

Interface
REQ-001 SHALL have parameter K, default 3: message bits per codeword, K >= 2.
REQ-002 SHALL have parameter M, default 3: parity-check rows and parity bits, M >= 1; N = K+M is derived, not a parameter.
REQ-003 SHALL state: one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- h_valid  in  1  H row offered.
- h_ready  out  1  H row accepted when h_valid & h_ready.
- h_row  in  N  H row; bits [N-1:M] hold the P part.
- msg_valid  in  1  message offered.
- msg_ready  out  1  message accepted when msg_valid & msg_ready.
- msg  in  K  message bits.
- cw_valid  out  1  codeword held.
- cw_ready  in  1  codeword consumed when cw_valid & cw_ready.
- cw  out  N  codeword.
- busy  out  1  high whenever state is not READY.

Function
REQ-005 SHALL implement states LOAD, READY, CALC, OUT.
REQ-006 LOAD SHALL assert h_ready and store h_row into row register r on each accepted beat, r counting 0..M-1.
- Acceptance of row M-1 moves to READY.
REQ-007 READY SHALL assert msg_ready only; an accepted msg is registered, the parity register is cleared, and the state moves to CALC.
REQ-008 CALC SHALL process one message bit per cycle, bit index k = 0..K-1 ascending, taking exactly K cycles.
- For each k with msg[k]=1: parity[r] ^= h_r[N-1-k] for every r.
REQ-009 Parity SHALL therefore be p_r = XOR over k of (msg[k] & h_r[N-1-k]), modulo-2, with no carries.
REQ-010 Codeword layout SHALL be cw[K-1:0] = msg and cw[K+r] = p_r.
- Equivalently, cw = XOR over k of msg[k]*g_k, with g_k[K+r] = h_r[N-1-k] and g_k[K-1:0] one-hot at bit k.
REQ-011 After the final CALC cycle the state SHALL be OUT with cw_valid=1.
- Latency is K+1 edges from the msg handshake edge to cw_valid high.
REQ-012 In OUT, cw and cw_valid SHALL hold stable until cw_ready; the handshake edge returns the state to READY.
- A new msg is accepted no earlier than the following cycle.
REQ-013 h_valid SHALL be ignored outside LOAD; msg_valid SHALL be ignored outside READY; cw_ready SHALL be ignored while cw_valid=0.
REQ-014 The row counter SHALL wrap to 0 when leaving LOAD; the bit counter SHALL clear on entry to CALC.
REQ-015 If cw_ready is already high on the cycle cw_valid rises, the handshake SHALL complete on that cycle (single-cycle OUT).
REQ-016 H SHALL be reloaded only after reset; there is no runtime reload path.

Reset
REQ-017 On rst_n=0 at a clock edge, the block SHALL enter LOAD with the following values:
- row and bit counters = 0.
- h_ready=1 from the first cycle after reset.
- msg_ready=0, cw_valid=0, cw=0, parity=0, busy=1.
- All H rows = 0.
REQ-018 Reset asserted mid-LOAD, mid-CALC or in OUT SHALL abort the operation with no codeword emitted; previously loaded H is discarded.

Configuration
REQ-019 Macro LDPC_GMAT_READ_EN SHALL, when defined, add the following ports:
- g_rd_en  in  1
- g_rd_idx  in  clog2(K)
- g_row  out  N
- g_rd_valid  out  1
REQ-020 With LDPC_GMAT_READ_EN defined, a g_rd_en pulse in any state except LOAD SHALL return g_k (REQ-010) for k = g_rd_idx on g_row one cycle later with g_rd_valid=1.
- idx >= K returns g_row=0 with g_rd_valid=1.
- g_row and g_rd_valid reset to 0.
REQ-021 Without LDPC_GMAT_READ_EN, these ports and their logic SHALL be absent; encoder behaviour SHALL be identical in both builds.

Verification (K=3, M=3)
REQ-022 Load h0=6'b101000, h1=6'b011000, h2=6'b110000, then msg=3'b101 -> cw=6'b110101, cw_valid high 4 edges after the msg handshake.
REQ-023 Same H; msg=3'b111 -> cw=6'b000111; msg=3'b000 -> cw=6'b000000.
REQ-024 Hold cw_ready=0 for 5 cycles in OUT with msg_valid=1 -> cw stable, msg_ready=0, exactly one codeword delivered.
REQ-025 Assert rst_n=0 during the 2nd CALC cycle -> next cycle LOAD, cw_valid=0, h_ready=1, all H rows=0.
REQ-026 With LDPC_GMAT_READ_EN defined: g_rd_idx=0 -> g_row=6'b101001; g_rd_idx=3 -> g_row=0; each with g_rd_valid one cycle after g_rd_en.
